// File: rtl/lif_pkg.sv
// Shared constants, event word layout and helpers for the LIF AER encoder.
// The optional timestamp field follows LIF_AER_TIMESTAMP_EN.
package lif_pkg;

    localparam int LIF_N_NEURONS  = 8;
    localparam int LIF_FIFO_DEPTH = 16;
    localparam int LIF_DROP_W     = 16;
`ifdef LIF_AER_TIMESTAMP_EN
    localparam int LIF_TS_W       = 16;
`endif

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LIF_ADDR_W = addr_width(LIF_N_NEURONS);
    localparam int LIF_CNT_W  = $clog2(LIF_N_NEURONS + 1);

    // Event widths are fixed here; change these constants to resize the encoder.
    typedef struct packed {
`ifdef LIF_AER_TIMESTAMP_EN
        logic [LIF_TS_W-1:0]   ts;
`endif
        logic [LIF_ADDR_W-1:0] addr;
    } aer_event_t;

    function automatic logic [LIF_CNT_W-1:0] popcount(input logic [LIF_N_NEURONS-1:0] v);
        logic [LIF_CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < LIF_N_NEURONS; i++) begin
            c = c + LIF_CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/lif_aer_fifo.sv
// Synchronous FIFO with a registered head word: data is visible the edge after
// the push that lands at the head, and stays stable until it is popped.
module lif_aer_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [LVL_W-1:0] level_reg;
    logic [WIDTH-1:0] head_reg;
    logic             do_push;
    logic             do_pop;
    logic             push_to_head;

    assign full         = (level_reg == LVL_W'(DEPTH));
    assign empty        = (level_reg == '0);
    assign do_push      = push && !full;
    assign do_pop       = pop && !empty;
    assign rd_ptr_next  = do_pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    // The pushed word becomes the head when nothing older survives this edge.
    assign push_to_head = do_push && (empty || (do_pop && level_reg == LVL_W'(1)));

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_reg + LVL_W'(do_push) - LVL_W'(do_pop);
            if (push_to_head) begin
                head_reg <= push_data;
            end else if (do_pop && level_reg > LVL_W'(1)) begin
                head_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign head_data = head_reg;
    assign level     = level_reg;

endmodule

// File: rtl/lif_aer_encoder.sv
// Serialises per-neuron spike bits into AER words through a FIFO, counting lost spikes.
// Optional LIF_AER_TIMESTAMP_EN adds a tick counter and the aer_ts port.
module lif_aer_encoder
    import lif_pkg::*;
#(
    parameter  int N_NEURONS  = LIF_N_NEURONS,
    parameter  int FIFO_DEPTH = LIF_FIFO_DEPTH,
`ifdef LIF_AER_TIMESTAMP_EN
    parameter  int TS_W       = LIF_TS_W,
`endif
    parameter  int DROP_W     = LIF_DROP_W,
    localparam int ADDR_W     = addr_width(N_NEURONS),
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_NEURONS-1:0] spike_in,
    output logic                 aer_valid,
    input  logic                 aer_ready,
    output logic [ADDR_W-1:0]    aer_addr,
`ifdef LIF_AER_TIMESTAMP_EN
    output logic [TS_W-1:0]      aer_ts,
`endif
    output logic [LVL_W-1:0]     fifo_level,
    output logic [DROP_W-1:0]    drop_count
);

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic [N_NEURONS-1:0] pend_reg;
    logic [N_NEURONS-1:0] grant;
    logic [N_NEURONS-1:0] lost;
    logic [ADDR_W-1:0]    grant_addr;
    logic                 push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DROP_W-1:0]    drop_reg;
    logic [DROP_W-1:0]    drop_next;
    logic [DROP_W:0]      drop_sum;
    aer_event_t           push_event;
    aer_event_t           head_event;

    // Lowest index wins; scanning downward leaves the lowest set bit last.
    always_comb begin
        grant      = '0;
        grant_addr = '0;
        if (!fifo_full) begin
            for (int i = N_NEURONS - 1; i >= 0; i--) begin
                if (pend_reg[i]) begin
                    grant      = '0;
                    grant[i]   = 1'b1;
                    grant_addr = ADDR_W'(i);
                end
            end
        end
    end

    assign push = |grant;

    generate
        for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_lost
            assign lost[gi] = spike_in[gi] & pend_reg[gi] & ~grant[gi];
        end
    endgenerate

    assign drop_sum  = {1'b0, drop_reg} + (DROP_W + 1)'(popcount(lost));
    assign drop_next = drop_sum[DROP_W] ? DROP_MAX : drop_sum[DROP_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_reg <= '0;
            drop_reg <= '0;
        end else begin
            pend_reg <= (pend_reg & ~grant) | spike_in;
            drop_reg <= drop_next;
        end
    end

`ifdef LIF_AER_TIMESTAMP_EN
    logic [TS_W-1:0] tick_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_reg <= '0;
        end else begin
            tick_reg <= tick_reg + 1'b1;
        end
    end
`endif

    always_comb begin
        push_event      = '0;
        push_event.addr = grant_addr;
`ifdef LIF_AER_TIMESTAMP_EN
        push_event.ts   = tick_reg;
`endif
    end

    lif_aer_fifo #(
        .WIDTH ($bits(aer_event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_event),
        .pop       (aer_ready),
        .head_data (head_event),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign aer_valid  = !fifo_empty;
    assign aer_addr   = head_event.addr;
`ifdef LIF_AER_TIMESTAMP_EN
    assign aer_ts     = head_event.ts;
`endif
    assign drop_count = drop_reg;

endmodule
